seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 4..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1): the request handshake.
REQ-005 The block SHALL have ports A (input, WIDTH), B (input, WIDTH) and SELC (input, 4): operands and opcode, sampled on accept.
REQ-006 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): the response handshake.
REQ-007 The block SHALL have port ALU_OUT, output, WIDTH: the registered result.
REQ-008 The block SHALL have ports CF, ZF, SF and DZ, each output, 1 bit: carry, zero, sign and divide-by-zero flags, registered.

Function
REQ-009 Accept SHALL occur when in_valid && in_ready; in_ready SHALL be 1 only in state IDLE.
REQ-010 Opcodes SHALL be: 0 ADD, 1 SUB, 2 MUL (low WIDTH bits), 3 DIV (quotient), 4 SHL, 5 SHR, 6 ROL, 7 ROR, 8 AND, 9 OR, A XOR, B NOR, C NAND, D XNOR, E GT (unsigned A>B gives 1, else 0), F EQ (A==B gives 1, else 0).
REQ-011 The FSM SHALL have states IDLE, BUSY and DONE; DONE is entered directly after accept for all ops except MUL/DIV.
REQ-012 MUL/DIV SHALL transition IDLE to BUSY, run exactly WIDTH iterations (shift-add / restoring divide), then go to DONE: out_valid rises WIDTH+1 cycles after accept.
REQ-013 Every other opcode, and DIV with B==0, SHALL assert out_valid 1 cycle after accept.
REQ-014 In DONE, out_valid=1 and ALU_OUT/flags SHALL hold stable until out_ready=1, then go to IDLE; a DONE-to-IDLE cycle SHALL precede the next accept, giving a maximum throughput of one op per 2 cycles.
REQ-015 CF SHALL be: ADD carry-out bit WIDTH; SUB borrow (A<B); MUL 1 if upper WIDTH product bits are nonzero; SHL A[WIDTH-1]; SHR A[0]; GT equal to result; 0 otherwise.
REQ-016 ZF SHALL be ALU_OUT==0 for opcodes 0..D; for EQ ZF=(A==B); for GT ZF=0.
REQ-017 SF SHALL be ALU_OUT[WIDTH-1] for opcodes 0..D and 0 for GT/EQ.
REQ-018 DIV with B==0 SHALL give ALU_OUT all-ones, DZ=1, CF=0, ZF=0, SF=1; DZ SHALL be 0 for every other result.
REQ-019 Operands SHALL be latched on accept; A/B/SELC changes during BUSY/DONE SHALL have no effect.
REQ-020 ALU_OUT and the flags SHALL update only on entry to DONE and SHALL otherwise hold their last value.

Reset
REQ-021 While rst=1 the FSM SHALL go to IDLE and ALU_OUT=0, CF=ZF=SF=DZ=0, out_valid=0, in_ready=0.
REQ-022 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-023 rst asserted during BUSY or DONE SHALL abort the operation with no out_valid pulse; a held result SHALL be discarded.

Structure
REQ-024 Package alu_pkg SHALL hold the 4-bit opcode constants, the FSM state encoding, and a WIDTH default constant shared with the successor of the combinational ALU.
REQ-025 The iterative multiply/divide SHALL be a sub-module alu_iter_muldiv (start/done, WIDTH-parametrised); all other ops SHALL be combinational in seq_alu.

Verification (WIDTH=8 unless stated)
REQ-026 ADD A=0xFF, B=0x01 -> after 1 cycle ALU_OUT=0x00, CF=1, ZF=1, SF=0.
REQ-027 MUL A=0x10, B=0x11 -> out_valid exactly 9 cycles after accept, ALU_OUT=0x10, CF=1; DIV A=200, B=7 -> ALU_OUT=28, 9 cycles.
REQ-028 DIV A=5, B=0 -> 1 cycle, ALU_OUT=0xFF, DZ=1, SF=1.
REQ-029 out_ready held 0 for 5 cycles after out_valid -> ALU_OUT/flags stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-030 rst pulsed at BUSY iteration 4 of a DIV -> no out_valid, outputs 0, next ADD 3+4 -> 7.
REQ-031 WIDTH=16: SUB A=0x0000, B=0x0001 -> ALU_OUT=0xFFFF, CF=1, SF=1; EQ A=B=0x1234 -> ALU_OUT=1, ZF=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and width default for the sequential ALU
// and the iterative multiply/divide engine.
package alu_pkg;

    localparam int ALU_WIDTH_DEFAULT = 8;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    // Divide by zero is resolved in one cycle, so it never enters the engine.
    function automatic logic is_iterative(input logic [3:0] op, input logic divisor_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !divisor_zero);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per clock.
// Result ports show the value after the current step so the final step can be captured as it happens.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] upper
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;
    logic             div_q;

    logic [WIDTH-1:0] hi_nx;
    logic [WIDTH-1:0] lo_nx;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;

    // hi holds partial product (mul) or partial remainder (div); lo holds multiplier or quotient bits.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        hi_nx   = hi_q;
        lo_nx   = lo_q;
        if (div_q) begin
            if (shifted >= {1'b0, b_q}) begin
                hi_nx = shifted[WIDTH-1:0] - b_q;
                lo_nx = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_nx = shifted[WIDTH-1:0];
                lo_nx = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nx = sum[WIDTH:1];
            lo_nx = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            div_q <= 1'b0;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
        end else if (start) begin
            run_q <= 1'b1;
            div_q <= op_div;
            cnt_q <= CW'(WIDTH);
            hi_q  <= '0;
            lo_q  <= a;
            b_q   <= b;
        end else if (run_q) begin
            hi_q  <= hi_nx;
            lo_q  <= lo_nx;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                run_q <= 1'b0;
            end
        end
    end

    assign done   = run_q && (cnt_q == CW'(1));
    assign result = lo_nx;
    assign upper  = hi_nx;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes; MUL/DIV run on the iterative engine,
// everything else resolves in one cycle.
//
// state   | meaning
// IDLE    | ready for a request (in_ready=1)
// BUSY    | multiply/divide iterating
// DONE    | result held, out_valid=1 until out_ready
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       SELC,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             CF,
    output logic             ZF,
    output logic             SF,
    output logic             DZ
);

    alu_state_t state_q;
    alu_state_t state_d;
    logic [3:0] op_q;

    logic accept;
    logic iter_start;

    logic [WIDTH-1:0] res_c;
    logic             cf_c;
    logic             zf_c;
    logic             sf_c;
    logic             dz_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   diff_c;

    logic             md_done;
    logic [WIDTH-1:0] md_result;
    logic [WIDTH-1:0] md_upper;

    assign in_ready   = (state_q == ST_IDLE) && !rst;
    assign out_valid  = (state_q == ST_DONE) && !rst;
    assign accept     = in_valid && in_ready;
    assign iter_start = accept && is_iterative(SELC, B == '0);

    always_comb begin
        res_c  = '0;
        cf_c   = 1'b0;
        dz_c   = 1'b0;
        sum_c  = {1'b0, A} + {1'b0, B};
        diff_c = {1'b0, A} - {1'b0, B};
        case (SELC)
            OP_ADD: begin
                res_c = sum_c[WIDTH-1:0];
                cf_c  = sum_c[WIDTH];
            end
            OP_SUB: begin
                res_c = diff_c[WIDTH-1:0];
                cf_c  = diff_c[WIDTH];
            end
            OP_DIV: begin
                res_c = '1;
                dz_c  = 1'b1;
            end
            OP_SHL: begin
                res_c = {A[WIDTH-2:0], 1'b0};
                cf_c  = A[WIDTH-1];
            end
            OP_SHR: begin
                res_c = {1'b0, A[WIDTH-1:1]};
                cf_c  = A[0];
            end
            OP_ROL:  res_c = {A[WIDTH-2:0], A[WIDTH-1]};
            OP_ROR:  res_c = {A[0], A[WIDTH-1:1]};
            OP_AND:  res_c = A & B;
            OP_OR:   res_c = A | B;
            OP_XOR:  res_c = A ^ B;
            OP_NOR:  res_c = ~(A | B);
            OP_NAND: res_c = ~(A & B);
            OP_XNOR: res_c = ~(A ^ B);
            OP_GT: begin
                res_c = {{(WIDTH-1){1'b0}}, (A > B)};
                cf_c  = (A > B);
            end
            OP_EQ:   res_c = {{(WIDTH-1){1'b0}}, (A == B)};
            default: res_c = '0;
        endcase
        zf_c = (res_c == '0);
        sf_c = res_c[WIDTH-1];
        if (SELC == OP_GT) begin
            zf_c = 1'b0;
            sf_c = 1'b0;
        end else if (SELC == OP_EQ) begin
            zf_c = (A == B);
            sf_c = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = iter_start ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            ALU_OUT <= '0;
            CF      <= 1'b0;
            ZF      <= 1'b0;
            SF      <= 1'b0;
            DZ      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= SELC;
            end
            if (accept && !iter_start) begin
                ALU_OUT <= res_c;
                CF      <= cf_c;
                ZF      <= zf_c;
                SF      <= sf_c;
                DZ      <= dz_c;
            end else if ((state_q == ST_BUSY) && md_done) begin
                ALU_OUT <= md_result;
                CF      <= (op_q == OP_MUL) && (md_upper != '0);
                ZF      <= (md_result == '0);
                SF      <= md_result[WIDTH-1];
                DZ      <= 1'b0;
            end
        end
    end

    alu_iter_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (iter_start),
        .op_div (SELC == OP_DIV),
        .a      (A),
        .b      (B),
        .done   (md_done),
        .result (md_result),
        .upper  (md_upper)
    );

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: an 8-bit and a 16-bit instance share clock and reset.
module tb_seq_alu;

    logic clk = 1'b0;
    logic rst;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, alu8;
    logic [3:0]  sel8;
    logic        cf8, zf8, sf8, dz8;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16, alu16;
    logic [3:0]  sel16;
    logic        cf16, zf16, sf16, dz16;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit          wide;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;   // {CF, ZF, SF, DZ}
        int          lat;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .A(a8), .B(b8), .SELC(sel8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .ALU_OUT(alu8), .CF(cf8), .ZF(zf8), .SF(sf8), .DZ(dz8)
    );

    seq_alu #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .A(a16), .B(b16), .SELC(sel16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .ALU_OUT(alu16), .CF(cf16), .ZF(zf16), .SF(sf16), .DZ(dz16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and returns the number of edges from accept (inclusive) to out_valid.
    task automatic run_op(input bit wide, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat,
                          output logic [31:0] res, output logic [3:0] fl);
        int guard = 0;
        while (!(wide ? in_ready16 : in_ready8) && guard < 50) begin
            step();
            guard++;
        end
        check("in_ready_before_op", {31'b0, (wide ? in_ready16 : in_ready8)}, 32'd1);
        if (wide) begin
            a16 = a[15:0]; b16 = b[15:0]; sel16 = op; in_valid16 = 1'b1;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; sel8 = op; in_valid8 = 1'b1;
        end
        @(posedge clk);
        lat = 1;
        #1;
        in_valid8 = 1'b0; in_valid16 = 1'b0;
        // Operands must already be latched; disturb them while the op runs.
        a8 = ~a8; b8 = 8'h00; sel8 = ~sel8;
        a16 = ~a16; b16 = 16'h0000; sel16 = ~sel16;
        while (!(wide ? out_valid16 : out_valid8) && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        if (wide) begin
            res = {16'b0, alu16};
            fl  = {cf16, zf16, sf16, dz16};
        end else begin
            res = {24'b0, alu8};
            fl  = {cf8, zf8, sf8, dz8};
        end
    endtask

    task automatic release_result();
        out_ready8 = 1'b1; out_ready16 = 1'b1;
        step();
        out_ready8 = 1'b0; out_ready16 = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic [3:0]  fl;
        int          seen;

        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; sel8 = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; sel16 = '0;

        //              wide op     a           b           res         CF ZF SF DZ  lat
        vecs.push_back('{1'b0, 4'h0, 32'hFF,   32'h01,   32'h00,   4'b1100, 1});
        vecs.push_back('{1'b0, 4'h2, 32'h10,   32'h11,   32'h10,   4'b1000, 9});
        vecs.push_back('{1'b0, 4'h3, 32'd200,  32'd7,    32'd28,   4'b0000, 9});
        vecs.push_back('{1'b0, 4'h3, 32'd5,    32'd0,    32'hFF,   4'b0011, 1});
        vecs.push_back('{1'b0, 4'h1, 32'h03,   32'h05,   32'hFE,   4'b1010, 1});
        vecs.push_back('{1'b0, 4'h4, 32'h81,   32'h00,   32'h02,   4'b1000, 1});
        vecs.push_back('{1'b0, 4'h5, 32'h81,   32'h00,   32'h40,   4'b1000, 1});
        vecs.push_back('{1'b0, 4'h6, 32'h81,   32'h00,   32'h03,   4'b0000, 1});
        vecs.push_back('{1'b0, 4'h7, 32'h81,   32'h00,   32'hC0,   4'b0010, 1});
        vecs.push_back('{1'b0, 4'h8, 32'hF0,   32'h3C,   32'h30,   4'b0000, 1});
        vecs.push_back('{1'b0, 4'h9, 32'hF0,   32'h0F,   32'hFF,   4'b0010, 1});
        vecs.push_back('{1'b0, 4'hA, 32'hF0,   32'h3C,   32'hCC,   4'b0010, 1});
        vecs.push_back('{1'b0, 4'hB, 32'hF0,   32'h0F,   32'h00,   4'b0100, 1});
        vecs.push_back('{1'b0, 4'hC, 32'hF0,   32'h3C,   32'hCF,   4'b0010, 1});
        vecs.push_back('{1'b0, 4'hD, 32'hF0,   32'h3C,   32'h33,   4'b0000, 1});
        vecs.push_back('{1'b0, 4'hE, 32'h05,   32'h03,   32'h01,   4'b1000, 1});
        vecs.push_back('{1'b0, 4'hE, 32'h03,   32'h05,   32'h00,   4'b0000, 1});
        vecs.push_back('{1'b0, 4'hF, 32'h07,   32'h07,   32'h01,   4'b0100, 1});
        vecs.push_back('{1'b0, 4'hF, 32'h07,   32'h08,   32'h00,   4'b0000, 1});
        vecs.push_back('{1'b0, 4'h2, 32'hFF,   32'hFF,   32'h01,   4'b1000, 9});
        vecs.push_back('{1'b0, 4'h3, 32'hFF,   32'h01,   32'hFF,   4'b0010, 9});
        vecs.push_back('{1'b0, 4'h3, 32'h03,   32'h07,   32'h00,   4'b0100, 9});
        vecs.push_back('{1'b1, 4'h1, 32'h0000, 32'h0001, 32'hFFFF, 4'b1010, 1});
        vecs.push_back('{1'b1, 4'hF, 32'h1234, 32'h1234, 32'h0001, 4'b0100, 1});
        vecs.push_back('{1'b1, 4'h2, 32'h0100, 32'h0100, 32'h0000, 4'b1100, 17});

        repeat (3) step();
        check("rst_in_ready", {31'b0, in_ready8}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid8}, 32'd0);
        check("rst_alu_out", {24'b0, alu8}, 32'd0);
        check("rst_flags", {28'b0, cf8, zf8, sf8, dz8}, 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", {31'b0, in_ready8}, 32'd1);

        foreach (vecs[i]) begin
            run_op(vecs[i].wide, vecs[i].op, vecs[i].a, vecs[i].b, lat, res, fl);
            check($sformatf("lat_v%0d_op%h", i, vecs[i].op), lat, vecs[i].lat);
            check($sformatf("res_v%0d_op%h", i, vecs[i].op), res, vecs[i].res);
            check($sformatf("flags_v%0d_op%h", i, vecs[i].op), {28'b0, fl}, {28'b0, vecs[i].fl});
            release_result();
        end

        // Back-pressure: result must hold while out_ready stays low, new requests ignored.
        run_op(1'b0, 4'h2, 32'h0F, 32'h0F, lat, res, fl);
        check("hold_res_initial", res, 32'hE1);
        for (int k = 0; k < 5; k++) begin
            in_valid8 = 1'b1; a8 = 8'h55; b8 = 8'h01; sel8 = 4'h0;
            step();
            check($sformatf("hold_res_%0d", k), {24'b0, alu8}, 32'hE1);
            check($sformatf("hold_flags_%0d", k), {28'b0, cf8, zf8, sf8, dz8}, 32'b0010);
            check($sformatf("hold_in_ready_%0d", k), {31'b0, in_ready8}, 32'd0);
            check($sformatf("hold_out_valid_%0d", k), {31'b0, out_valid8}, 32'd1);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;
        check("hold_release_in_ready", {31'b0, in_ready8}, 32'd1);
        check("hold_release_out_valid", {31'b0, out_valid8}, 32'd0);
        check("hold_release_res_kept", {24'b0, alu8}, 32'hE1);

        // Reset during the fourth divide iteration aborts the op.
        a8 = 8'd200; b8 = 8'd7; sel8 = 4'h3; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        repeat (4) step();
        check("abort_busy_no_valid", {31'b0, out_valid8}, 32'd0);
        rst = 1'b1;
        #1;
        check("abort_rst_in_ready", {31'b0, in_ready8}, 32'd0);
        check("abort_rst_out_valid", {31'b0, out_valid8}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("abort_alu_cleared", {24'b0, alu8}, 32'd0);
        check("abort_flags_cleared", {28'b0, cf8, zf8, sf8, dz8}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready8}, 32'd1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (out_valid8) seen++;
        end
        check("abort_no_valid_pulse", seen, 0);
        run_op(1'b0, 4'h0, 32'd3, 32'd4, lat, res, fl);
        check("post_abort_lat", lat, 1);
        check("post_abort_res", res, 32'd7);
        check("post_abort_flags", {28'b0, fl}, 32'd0);
        release_result();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
